// File: rtl/output_stream_collector.sv
// Collects in_valid-pulsed words into a small FWFT FIFO and replays them as an
// AXI4-Stream frame of OUT_MAX beats, tlast on the final frame index.
module output_stream_collector #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OUT_MAX    = 262144,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       rx_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DATA_W + 1;
  localparam logic [31:0] FRAME_LEN = 32'(OUT_MAX);
  localparam logic [31:0] LAST_IDX  = 32'(OUT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     rx_count_q, rx_count_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            empty;
  logic            full;
  logic            pop;
  logic            push_req;
  logic            push;
  logic            last_flag;
  logic [EW-1:0]   head;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = !empty && m_axis_tready;
  assign push_req  = (state_q == S_RUN) && in_valid && (rx_count_q < FRAME_LEN);
  assign push      = push_req && (!full || pop);
  assign last_flag = (rx_count_q == LAST_IDX);
  assign head      = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    rx_count_d = rx_count_q;
    overflow_d = overflow_q;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d    = S_RUN;
          rx_count_d = '0;
          overflow_d = 1'b0;
        end
      end
      S_RUN: begin
        if (push_req) begin
          rx_count_d = rx_count_q + 32'd1;
          if (!push) overflow_d = 1'b1;
          if (last_flag) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // No pushes here, so the FIFO is empty next cycle iff wr == next rd.
        if (wr_ptr_q == rd_ptr_d) state_d = S_DONE;
      end
      S_DONE: begin
        if (!en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rx_count_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rx_count_q <= rx_count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Storage entry: {last, data}; cleared on reset so the idle head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {last_flag, in_data};
    end
  end

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = head[DATA_W-1:0];
  assign m_axis_tlast  = !empty && head[DATA_W];
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign rx_count      = rx_count_q;

endmodule

// File: tb/tb_output_stream_collector.sv
// Directed bench for output_stream_collector with OUT_MAX=8, FIFO_DEPTH=4.
module tb_output_stream_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [31:0] in_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        done;
  logic        overflow;
  logic [31:0] rx_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [32:0] beats [$];
  logic [32:0] b;

  output_stream_collector #(
    .DATA_W(32), .OUT_MAX(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .done(done), .overflow(overflow), .rx_count(rx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Record any beat handed over at the coming edge, then step past that edge.
  task automatic cyc();
    if (m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_data = '0; m_axis_tready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rx_count", rx_count, 0);
    #8 rst = 1'b0;
    @(posedge clk); #1;

    // Pulses while idle are ignored
    in_valid = 1'b1; in_data = 32'd5; cyc(); in_valid = 1'b0;
    chk("idle_rx_count", rx_count, 0);
    chk("idle_tvalid", m_axis_tvalid, 0);

    // Frame 1: spaced pulses 0..7, tready high
    m_axis_tready = 1'b1; en = 1'b1; cyc();
    chk("f1_start_rx", rx_count, 0);
    beats.delete();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 32'(i); cyc(); in_valid = 1'b0;
      repeat (5) cyc();
    end
    chk("f1_rx7", rx_count, 7);
    chk("f1_done_early", done, 0);
    in_valid = 1'b1; in_data = 32'd7; cyc();
    chk("f1_last_tvalid", m_axis_tvalid, 1);
    chk("f1_last_tdata", m_axis_tdata, 7);
    chk("f1_last_tlast", m_axis_tlast, 1);
    chk("f1_last_done", done, 0);
    chk("f1_rx8", rx_count, 8);
    in_data = 32'd99; cyc(); in_valid = 1'b0;   // pulse during DRAIN
    chk("f1_done", done, 1);
    chk("f1_tvalid_end", m_axis_tvalid, 0);
    chk("f1_rx_drain", rx_count, 8);
    chk("f1_nbeats", beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      b = beats[i];
      chk($sformatf("f1_beat%0d_data", i), b[31:0], 64'(i));
      chk($sformatf("f1_beat%0d_last", i), b[32], (i == 7) ? 64'd1 : 64'd0);
    end
    chk("f1_overflow", overflow, 0);

    // Pulses in DONE are ignored
    repeat (2) begin
      in_valid = 1'b1; in_data = 32'd100; cyc(); in_valid = 1'b0; cyc();
    end
    chk("done_rx", rx_count, 8);
    chk("done_tvalid", m_axis_tvalid, 0);
    chk("done_nbeats", beats.size(), 8);
    chk("done_hold", done, 1);

    // Frame 2: stalled sink, overflow on the 5th pulse, last word dropped
    en = 1'b0; cyc();
    chk("f2_idle_done", done, 0);
    en = 1'b1; cyc();
    chk("f2_start_rx", rx_count, 0);
    m_axis_tready = 1'b0; beats.delete();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 32'(10 + i); cyc();
      if (i == 3) chk("f2_ovf_after4", overflow, 0);
      if (i == 4) chk("f2_ovf_after5", overflow, 1);
    end
    in_valid = 1'b0;
    chk("f2_rx6", rx_count, 6);
    chk("f2_tvalid", m_axis_tvalid, 1);
    chk("f2_tdata", m_axis_tdata, 10);
    chk("f2_tlast", m_axis_tlast, 0);
    repeat (3) cyc();
    chk("f2_tdata_held", m_axis_tdata, 10);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'(16 + i); cyc();
    end
    in_valid = 1'b0;
    chk("f2_rx8", rx_count, 8);
    chk("f2_not_done", done, 0);
    m_axis_tready = 1'b1;
    repeat (4) cyc();
    chk("f2_done", done, 1);
    chk("f2_nbeats", beats.size(), 4);
    for (int i = 0; i < 4; i++) begin
      b = beats[i];
      chk($sformatf("f2_beat%0d_data", i), b[31:0], 64'(10 + i));
      chk($sformatf("f2_beat%0d_last", i), b[32], 0);
    end
    chk("f2_overflow_end", overflow, 1);

    // Frame 3: restart clears overflow; push+pop on a full FIFO is accepted
    en = 1'b0; cyc(); en = 1'b1; cyc();
    chk("f3_ovf_cleared", overflow, 0);
    chk("f3_rx_cleared", rx_count, 0);
    m_axis_tready = 1'b0; beats.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'(20 + i); cyc();
    end
    in_data = 32'd24; m_axis_tready = 1'b1; cyc();
    chk("f3_full_tdata", m_axis_tdata, 21);
    chk("f3_full_ovf", overflow, 0);
    chk("f3_full_rx", rx_count, 5);
    for (int i = 25; i < 28; i++) begin
      in_data = 32'(i); cyc();
    end
    in_valid = 1'b0;
    chk("f3_ovf", overflow, 0);
    chk("f3_rx8", rx_count, 8);
    chk("f3_nbeats_mid", beats.size(), 4);
    repeat (4) cyc();
    chk("f3_done", done, 1);
    chk("f3_nbeats", beats.size(), 8);
    for (int i = 0; i < 8; i++) begin
      b = beats[i];
      chk($sformatf("f3_beat%0d_data", i), b[31:0], 64'(20 + i));
      chk($sformatf("f3_beat%0d_last", i), b[32], (i == 7) ? 64'd1 : 64'd0);
    end

    // Frame 4: asynchronous reset mid-frame
    en = 1'b0; cyc(); en = 1'b1; cyc();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'(30 + i); cyc();
    end
    in_valid = 1'b0;
    chk("f4_pre_ovf", overflow, 1);
    chk("f4_pre_tvalid", m_axis_tvalid, 1);
    chk("f4_pre_rx", rx_count, 5);
    #2 rst = 1'b1; en = 1'b0;
    #1;
    chk("f4_rst_tvalid", m_axis_tvalid, 0);
    chk("f4_rst_ovf", overflow, 0);
    chk("f4_rst_rx", rx_count, 0);
    chk("f4_rst_done", done, 0);
    chk("f4_rst_tdata", m_axis_tdata, 0);
    chk("f4_rst_tlast", m_axis_tlast, 0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'd50; cyc(); in_valid = 1'b0;
    chk("f4_idle_rx", rx_count, 0);
    chk("f4_idle_tvalid", m_axis_tvalid, 0);
    en = 1'b1; cyc();
    in_valid = 1'b1; in_data = 32'd40; cyc(); in_valid = 1'b0;
    chk("f4_run_rx", rx_count, 1);
    chk("f4_run_tvalid", m_axis_tvalid, 1);
    chk("f4_run_tdata", m_axis_tdata, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
